// File: rtl/bp_types.sv
// Shared types for the tournament branch predictor: the 4-bit prediction
// snapshot layout and the counter reset value.
package bp_types;

    typedef logic [3:0] bp_vec_t;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;
    localparam int BP_LAST    = 2;
    localparam int BP_CHOOSE  = 3;

    localparam logic [1:0] CTR_INIT = 2'b01;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating counter: step toward inc, clamp at 00/11.
module sat_counter2 (
    input  logic [1:0] cur,
    input  logic       inc,
    output logic [1:0] next
);

    always_comb begin
        next = cur;
        if (inc) begin
            if (cur != 2'b11) next = cur + 2'd1;
        end else begin
            if (cur != 2'b00) next = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Tournament predictor (bimodal / gshare / last-outcome, chooser-selected).
// Optional resolution statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
    import bp_types::*;
#(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_en,
    input  logic [31:0] pred_pc,
    output logic        prediction,
    output logic [3:0]  all_prediction,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [3:0]  upd_all_prediction,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);

    localparam int ENTRIES = 1 << IDX_BITS;

    if (GHR_BITS > IDX_BITS || GHR_BITS < 2) begin : g_bad_ghr
        $error("branch_predictor: GHR_BITS must be in [2, IDX_BITS]");
    end

    logic [1:0]          bim [ENTRIES];
    logic [1:0]          gsh [ENTRIES];
    logic [1:0]          cho [ENTRIES];
    logic [ENTRIES-1:0]  last;
    logic [GHR_BITS-1:0] ghr;

    // Prediction side: combinational table read, registered on pred_en.
    logic [IDX_BITS-1:0] bidx, gidx;
    bp_vec_t             pred_vec;

    assign bidx = pred_pc[IDX_BITS+1:2];
    assign gidx = bidx ^ IDX_BITS'(ghr);

    always_comb begin
        pred_vec              = '0;
        pred_vec[BP_BIMODAL]  = bim[bidx][1];
        pred_vec[BP_GSHARE]   = gsh[gidx][1];
        pred_vec[BP_LAST]     = last[bidx];
        pred_vec[BP_CHOOSE]   = cho[bidx][1];
    end

    // Update side uses the GHR at resolution time, not the one seen at prediction.
    logic [IDX_BITS-1:0] ubidx, ugidx;
    logic [1:0]          bim_nxt, gsh_nxt, cho_nxt;
    logic                cho_en, cho_inc;

    assign ubidx   = upd_pc[IDX_BITS+1:2];
    assign ugidx   = ubidx ^ IDX_BITS'(ghr);
    assign cho_en  = upd_all_prediction[BP_BIMODAL] ^ upd_all_prediction[BP_GSHARE];
    assign cho_inc = upd_all_prediction[BP_GSHARE] == upd_taken;

    sat_counter2 u_bim (.cur(bim[ubidx]), .inc(upd_taken), .next(bim_nxt));
    sat_counter2 u_gsh (.cur(gsh[ugidx]), .inc(upd_taken), .next(gsh_nxt));
    sat_counter2 u_cho (.cur(cho[ubidx]), .inc(cho_inc),   .next(cho_nxt));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bim[i] <= CTR_INIT;
                gsh[i] <= CTR_INIT;
                cho[i] <= CTR_INIT;
            end
            last           <= '0;
            ghr            <= '0;
            prediction     <= 1'b0;
            all_prediction <= '0;
        end else begin
            if (pred_en) begin
                all_prediction <= pred_vec;
                prediction     <= pred_vec[BP_CHOOSE] ? pred_vec[BP_GSHARE]
                                                      : pred_vec[BP_BIMODAL];
            end
            if (upd_valid) begin
                bim[ubidx]  <= bim_nxt;
                gsh[ugidx]  <= gsh_nxt;
                last[ubidx] <= upd_taken;
                if (cho_en) cho[ubidx] <= cho_nxt;
                ghr <= {ghr[GHR_BITS-2:0], upd_taken};
            end
        end
    end

`ifdef BP_STATS_EN
    logic upd_final;
    assign upd_final = upd_all_prediction[BP_CHOOSE] ? upd_all_prediction[BP_GSHARE]
                                                     : upd_all_prediction[BP_BIMODAL];

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (upd_taken != upd_final) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

    // PC bits outside the index never matter; the snapshot's chooser bit only feeds stats.
    logic unused_bits;
    assign unused_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                           upd_pc[31:IDX_BITS+2], upd_pc[1:0],
                           upd_all_prediction[BP_LAST], upd_all_prediction[BP_CHOOSE]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed table, history and stats values.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_en;
    logic [31:0] pred_pc;
    logic        prediction;
    logic [3:0]  all_prediction;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [3:0]  upd_all_prediction;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst(rst),
        .pred_en(pred_en), .pred_pc(pred_pc),
        .prediction(prediction), .all_prediction(all_prediction),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_all_prediction(upd_all_prediction),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [3:0] snap);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_all_prediction = snap;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
`ifdef BP_STATS_EN
        chk({tag, "_branches"}, stat_branches, br);
        chk({tag, "_mispred"},  stat_mispred,  mp);
`else
        chk({tag, "_branches"}, stat_branches, 32'd0);
        chk({tag, "_mispred"},  stat_mispred,  32'd0);
        if (br == 32'hFFFF_FFFF || mp == 32'hFFFF_FFFF) $display("note: unexpected stat args");
`endif
    endtask

    initial begin
        rst = 1'b0; pred_en = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_all_prediction = '0;
        step(); step();
        chk("rst_pred", {31'd0, prediction}, 32'd0);
        chk("rst_all",  {28'd0, all_prediction}, 32'd0);
        chk_stats("rst", 32'd0, 32'd0);

        // Untrained lookup
        rst = 1'b1; pred_en = 1'b1; pred_pc = 32'h60;
        step();
        pred_en = 1'b0;
        chk("cold_pred", {31'd0, prediction}, 32'd0);
        chk("cold_all",  {28'd0, all_prediction}, 32'd0);

        // Two taken at 0x60: bimodal 11, gshare trains 24 and 25, GHR=...11
        upd(32'h60, 1'b1, 4'b0000);
        upd(32'h60, 1'b1, 4'b0000);
        pred_en = 1'b1; pred_pc = 32'h63;  // low bits ignored
        step();
        pred_en = 1'b0;
        chk("train_all",  {28'd0, all_prediction}, 32'h5);
        chk("train_pred", {31'd0, prediction}, 32'd1);

        // Saturation at 0x80: 5 taken then 1 not-taken -> bimodal 10
        for (int i = 0; i < 5; i++) upd(32'h80, 1'b1, 4'b0000);
        upd(32'h80, 1'b0, 4'b0000);
        chk_stats("sat", 32'd8, 32'd7);
        pred_en = 1'b1; pred_pc = 32'h80;
        step();
        pred_en = 1'b0;
        chk("sat_all",  {28'd0, all_prediction}, 32'h1);
        chk("sat_pred", {31'd0, prediction}, 32'd1);

        // Chooser training at 0xC0 toward gshare
        upd(32'hC0, 1'b1, 4'b0010);
        upd(32'hC0, 1'b1, 4'b0010);
        pred_en = 1'b1; pred_pc = 32'hC0;
        step();
        pred_en = 1'b0;
        chk("cho_all",  {28'd0, all_prediction}, 32'hD);
        chk("cho_pred", {31'd0, prediction}, 32'd0);

        // Agreeing components leave the chooser alone
        upd(32'hC0, 1'b0, 4'b0011);
        upd(32'hC0, 1'b0, 4'b0011);
        pred_en = 1'b1; pred_pc = 32'hC0;
        step();
        pred_en = 1'b0;
        chk("cho_hold_all",  {28'd0, all_prediction}, 32'h8);
        chk("cho_hold_pred", {31'd0, prediction}, 32'd0);

        // Same-cycle read/write of entry 0 (pc 0x100)
        pred_en = 1'b1; pred_pc = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_all_prediction = 4'b1010;
        step();
        upd_valid = 1'b0;
        chk("coll_old_all", {28'd0, all_prediction}, 32'h0);
        chk("coll_old_bit0", {31'd0, all_prediction[0]}, 32'd0);
        step();
        chk("coll_new_all",  {28'd0, all_prediction}, 32'hF);
        chk("coll_new_pred", {31'd0, prediction}, 32'd1);
        chk_stats("coll", 32'd13, 32'd11);

        // pred_en low: outputs hold
        pred_en = 1'b0; pred_pc = 32'h60;
        step();
        chk("hold_all",  {28'd0, all_prediction}, 32'hF);
        chk("hold_pred", {31'd0, prediction}, 32'd1);

        // Reset wins over simultaneous pred_en / upd_valid
        rst = 1'b0; pred_en = 1'b1; pred_pc = 32'h60;
        upd_valid = 1'b1; upd_pc = 32'h60; upd_taken = 1'b1; upd_all_prediction = 4'b0000;
        step();
        chk("rst2_all",  {28'd0, all_prediction}, 32'h0);
        chk("rst2_pred", {31'd0, prediction}, 32'd0);
        chk_stats("rst2", 32'd0, 32'd0);
        rst = 1'b1; upd_valid = 1'b0; pred_pc = 32'h100;
        step();
        chk("post_rst_all", {28'd0, all_prediction}, 32'h0);
        pred_pc = 32'h60;
        step();
        chk("post_rst_all60", {28'd0, all_prediction}, 32'h0);
        chk("post_rst_pred",  {31'd0, prediction}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
